piso_tx: RTL and testbench
==========================

PISO_TX -- requirements
Module: piso_tx

Interface
REQ-001 SHALL have parameter WIDTH, default 4, parallel word width in bits (WIDTH >= 2).
REQ-002 SHALL have parameter MSB_FIRST, default 1; 1 = bit WIDTH-1 shifted first, 0 = bit 0 first.
REQ-003 SHALL have port clk  input  1  single clock, all state on rising edge.
REQ-004 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port din  input  WIDTH  parallel word to serialize.
REQ-006 SHALL have port din_valid  input  1  din holds a valid word.
REQ-007 SHALL have port din_ready  output  1  block accepts din this cycle.
REQ-008 SHALL have port sout  output  1  serial bit; drives the downstream sipo_reg d input.
REQ-009 SHALL have port sout_valid  output  1  sout carries a word bit this cycle.
REQ-010 SHALL have port last  output  1  sout carries the final bit of a word.
REQ-011 SHALL have port busy  output  1  shifter active or holding buffer full.

Function
REQ-012 SHALL contain a WIDTH-bit shifter, a bit counter of ceil(log2(WIDTH)) bits, a one-entry holding buffer with full flag, and FSM states IDLE, SHIFT.
REQ-013 SHALL drive din_ready = !buf_full combinationally while rst_n high; handshake occurs on a rising edge with din_valid && din_ready.
REQ-014 SHALL route an accepted word directly to the shifter when the shifter is free next cycle (state IDLE, or SHIFT with last=1), else into the holding buffer.
REQ-015 SHALL load the shifter from the holding buffer, clearing buf_full, on the edge where SHIFT has last=1 and buf_full=1; buffer load has priority (din_ready is 0 then, so no conflict).
REQ-016 SHALL register outputs: a word accepted/loaded at edge k drives sout_valid=1 and bits on cycles k+1..k+WIDTH, one bit per cycle, order per MSB_FIRST.
REQ-017 SHALL assert last only on cycle k+WIDTH of each word; counter runs 0..WIDTH-1 and resets to 0 on each load.
REQ-018 SHALL transition IDLE->SHIFT on a load; SHIFT->SHIFT on last=1 with a new load (zero-gap streaming); SHIFT->IDLE on last=1 with no load.
REQ-019 SHALL, in IDLE, drive sout=0, sout_valid=0, last=0.
REQ-020 SHALL sample din only at the handshake; later din changes do not affect the word in flight.
REQ-021 SHALL, at the last-bit cycle with buffer empty and din_valid=1, accept din and start its first bit next cycle with no gap.
REQ-022 SHALL hold at most two words (shifter + buffer); din_ready=0 whenever buf_full=1.
REQ-023 SHALL drive busy = (state==SHIFT) || buf_full.

Reset
REQ-024 SHALL, while rst_n=0 (immediately, asynchronously), force state=IDLE, shifter=0, counter=0, buf_full=0, sout=0, sout_valid=0, last=0, din_ready=0, busy=0.
REQ-025 SHALL discard any partial word and buffered word on reset mid-operation; no further bits of them appear after rst_n rises.
REQ-026 SHALL assert din_ready=1 in the first cycle after rst_n deasserts.

Verification
REQ-027 WIDTH=4, MSB_FIRST=1: single handshake din=4'b1011 -> sout 1,0,1,1 on next 4 cycles, sout_valid=1 for exactly those 4, last=1 on 4th only, then IDLE.
REQ-028 Back-to-back 4'hA then 4'h5 held valid -> 8 contiguous bits 1,0,1,0,0,1,0,1 with no sout_valid gap; din_ready=0 while 4'h5 sits in buffer.
REQ-029 MSB_FIRST=0: din=4'b1011 -> sout 1,1,0,1; last on 4th bit.
REQ-030 Third word offered while shifter and buffer full -> din_ready=0, word not accepted until buffer drains; no word lost or duplicated.
REQ-031 rst_n pulsed low during bit 2 of 4'hC with 4'h3 buffered -> outputs zero immediately, neither word resumes; next word 4'h9 after reset shifts cleanly 1,0,0,1.
REQ-032 Chained into sipo_reg (4-bit): after 4'hA shifted MSB-first, sipo_reg q equals 4'hA on the cycle after last.

Source files
------------

// File: rtl/piso_tx.sv
// piso_tx: parallel-in / serial-out transmitter.
// Accepts WIDTH-bit words on a valid/ready handshake and emits them one bit
// per clock on sout, qualified by sout_valid, with last marking the final
// bit. A one-entry holding buffer lets the next word wait behind the word
// being shifted, so consecutive words stream out with no idle cycle between.

module piso_tx #(
  parameter int WIDTH     = 4,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] din,
  input  logic             din_valid,
  output logic             din_ready,
  output logic             sout,
  output logic             sout_valid,
  output logic             last,
  output logic             busy
);

  localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  state_t             state_q,      state_d;
  logic [WIDTH-1:0]   shifter_q,    shifter_d;
  logic [CNT_W-1:0]   cnt_q,        cnt_d;
  logic [WIDTH-1:0]   buf_q,        buf_d;
  logic               buf_full_q,   buf_full_d;
  logic               sout_q,       sout_d;
  logic               sout_valid_q, sout_valid_d;
  logic               last_q,       last_d;

  logic               accept;
  logic               shifter_free;
  logic               load_from_buf;
  logic               load_from_din;
  logic [WIDTH-1:0]   load_word;
  logic [CNT_W-1:0]   cnt_next;

  // Bit that leaves the word first, according to the configured order.
  function automatic logic first_bit(input logic [WIDTH-1:0] w);
    if (MSB_FIRST)
      first_bit = w[WIDTH-1];
    else
      first_bit = w[0];
  endfunction

  // Word with its outgoing bit removed, so the next bit sits in the exit slot.
  function automatic logic [WIDTH-1:0] advance(input logic [WIDTH-1:0] w);
    if (MSB_FIRST)
      advance = {w[WIDTH-2:0], 1'b0};
    else
      advance = {1'b0, w[WIDTH-1:1]};
  endfunction

  // Handshake qualifiers; ready is held low while reset is asserted.
  always_comb begin
    din_ready     = rst_n && !buf_full_q;
    accept        = din_valid && din_ready;
    shifter_free  = (state_q == IDLE) || last_q;
    load_from_buf = shifter_free && buf_full_q;
    load_from_din = shifter_free && !buf_full_q && accept;
    load_word     = load_from_buf ? buf_q : din;
    cnt_next      = cnt_q + 1'b1;
  end

  // Next-state logic for the shifter, counter, buffer and registered outputs.
  always_comb begin
    state_d      = state_q;
    shifter_d    = shifter_q;
    cnt_d        = cnt_q;
    buf_d        = buf_q;
    buf_full_d   = buf_full_q;
    sout_d       = sout_q;
    sout_valid_d = sout_valid_q;
    last_d       = last_q;

    if (load_from_buf || load_from_din) begin
      // A fresh word starts: its first bit appears on the next cycle.
      state_d      = SHIFT;
      sout_d       = first_bit(load_word);
      shifter_d    = advance(load_word);
      cnt_d        = '0;
      sout_valid_d = 1'b1;
      last_d       = 1'b0;
    end else if (state_q == SHIFT) begin
      if (last_q) begin
        // Final bit done and nothing queued: fall back to a quiet line.
        state_d      = IDLE;
        shifter_d    = '0;
        cnt_d        = '0;
        sout_d       = 1'b0;
        sout_valid_d = 1'b0;
        last_d       = 1'b0;
      end else begin
        sout_d       = first_bit(shifter_q);
        shifter_d    = advance(shifter_q);
        cnt_d        = cnt_next;
        last_d       = (cnt_next == CNT_LAST);
      end
    end

    // The buffer empties when its word moves into the shifter.
    if (load_from_buf) begin
      buf_full_d = 1'b0;
    end

    // A word arriving while the shifter is still busy waits in the buffer.
    if (accept && !shifter_free) begin
      buf_d      = din;
      buf_full_d = 1'b1;
    end
  end

  // State and output registers; reset discards any word in flight or queued.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      shifter_q    <= '0;
      cnt_q        <= '0;
      buf_q        <= '0;
      buf_full_q   <= 1'b0;
      sout_q       <= 1'b0;
      sout_valid_q <= 1'b0;
      last_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      shifter_q    <= shifter_d;
      cnt_q        <= cnt_d;
      buf_q        <= buf_d;
      buf_full_q   <= buf_full_d;
      sout_q       <= sout_d;
      sout_valid_q <= sout_valid_d;
      last_q       <= last_d;
    end
  end

  // Outputs come straight from flops so the serial line is glitch-free.
  always_comb begin
    sout       = sout_q;
    sout_valid = sout_valid_q;
    last       = last_q;
    busy       = (state_q == SHIFT) || buf_full_q;
  end

endmodule

// File: tb/tb_piso_tx.sv
// Directed testbench for piso_tx: an MSB-first and an LSB-first instance,
// plus a small serial-in shift register model fed from the MSB-first line.

module tb_piso_tx;

  logic       clk;
  logic       rst_n;

  logic [3:0] din;
  logic       dinValid;
  logic       dinReady;
  logic       sout;
  logic       soutValid;
  logic       last;
  logic       busy;

  logic [3:0] din2;
  logic       dinValid2;
  logic       dinReady2;
  logic       sout2;
  logic       soutValid2;
  logic       last2;
  logic       busy2;

  logic [3:0] sipoQ;

  int checkCount;
  int errorCount;

  piso_tx #(.WIDTH(4), .MSB_FIRST(1'b1)) dutMsb (
    .clk        (clk),
    .rst_n      (rst_n),
    .din        (din),
    .din_valid  (dinValid),
    .din_ready  (dinReady),
    .sout       (sout),
    .sout_valid (soutValid),
    .last       (last),
    .busy       (busy)
  );

  piso_tx #(.WIDTH(4), .MSB_FIRST(1'b0)) dutLsb (
    .clk        (clk),
    .rst_n      (rst_n),
    .din        (din2),
    .din_valid  (dinValid2),
    .din_ready  (dinReady2),
    .sout       (sout2),
    .sout_valid (soutValid2),
    .last       (last2),
    .busy       (busy2)
  );

  // Free-running clock, 10 time units per period.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Downstream 4-bit serial-in register capturing valid bits, MSB first.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      sipoQ <= 4'h0;
    else if (soutValid)
      sipoQ <= {sipoQ[2:0], sout};
  end

  // Single comparison point: counts every check and reports mismatches.
  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    checkCount++;
    if (actual !== expected) begin
      errorCount++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, actual, expected);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic clkStep();
    @(posedge clk);
    #1;
  endtask

  // Compare all MSB-instance outputs for one cycle.
  task automatic checkCycle(input string tag, input int i, input logic s, input logic v,
                            input logic l, input logic r, input logic b);
    checkOutput($sformatf("%s_sout[%0d]", tag, i), sout, s);
    checkOutput($sformatf("%s_valid[%0d]", tag, i), soutValid, v);
    checkOutput($sformatf("%s_last[%0d]", tag, i), last, l);
    checkOutput($sformatf("%s_ready[%0d]", tag, i), dinReady, r);
    checkOutput($sformatf("%s_busy[%0d]", tag, i), busy, b);
  endtask

  logic [12:0] expS, expV, expL, expR, expB;

  // Directed scenarios with hand-derived per-cycle expectations.
  initial begin : applyStimulus
    checkCount = 0;
    errorCount = 0;
    rst_n      = 1'b0;
    din        = 4'h0;
    dinValid   = 1'b0;
    din2       = 4'h0;
    dinValid2  = 1'b0;

    // Reset state.
    clkStep();
    clkStep();
    checkCycle("reset", 0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    checkOutput("reset_lsb_ready", dinReady2, 1'b0);

    rst_n = 1'b1;
    #1;
    checkOutput("post_reset_ready", dinReady, 1'b1);
    checkOutput("post_reset_busy", busy, 1'b0);
    clkStep();

    // Single word 1011, din scrambled after handshake.
    din      = 4'b1011;
    dinValid = 1'b1;
    expS = 13'b10110_00000000;
    expV = 13'b11110_00000000;
    expL = 13'b00010_00000000;
    expR = 13'b11111_00000000;
    expB = 13'b11110_00000000;
    for (int i = 0; i < 5; i++) begin
      clkStep();
      checkCycle("single", i, expS[12-i], expV[12-i], expL[12-i], expR[12-i], expB[12-i]);
      if (i == 0) begin
        dinValid = 1'b0;
        din      = 4'b0000;
      end
    end

    // Back-to-back A then 5, zero-gap streaming.
    din      = 4'hA;
    dinValid = 1'b1;
    expS = 13'b101001010_0000;
    expV = 13'b111111110_0000;
    expL = 13'b000100010_0000;
    expR = 13'b100011111_0000;
    expB = 13'b111111110_0000;
    for (int i = 0; i < 9; i++) begin
      clkStep();
      checkCycle("stream", i, expS[12-i], expV[12-i], expL[12-i], expR[12-i], expB[12-i]);
      if (i == 4) checkOutput("sipo_after_A", sipoQ, 4'hA);
      if (i == 8) checkOutput("sipo_after_5", sipoQ, 4'h5);
      if (i == 0) din = 4'h5;
      if (i == 1) begin
        dinValid = 1'b0;
        din      = 4'h0;
      end
    end

    // Third word 9/6/E held while shifter and buffer are full.
    din      = 4'h9;
    dinValid = 1'b1;
    expS = 13'b1001011011100;
    expV = 13'b1111111111110;
    expL = 13'b0001000100010;
    expR = 13'b1000100011111;
    expB = 13'b1111111111110;
    for (int i = 0; i < 13; i++) begin
      clkStep();
      checkCycle("third", i, expS[12-i], expV[12-i], expL[12-i], expR[12-i], expB[12-i]);
      if (i == 0) din = 4'h6;
      if (i == 1) din = 4'hE;
      if (i == 5) begin
        dinValid = 1'b0;
        din      = 4'h0;
      end
    end

    // Reset during bit 2 of C with 3 buffered.
    din      = 4'hC;
    dinValid = 1'b1;
    clkStep();
    checkOutput("midrst_bit1", sout, 1'b1);
    din = 4'h3;
    clkStep();
    checkOutput("midrst_bit2", sout, 1'b1);
    checkOutput("midrst_buf_ready", dinReady, 1'b0);
    dinValid = 1'b0;
    din      = 4'h0;
    rst_n    = 1'b0;
    #1;
    checkCycle("midrst_async", 0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    clkStep();
    clkStep();
    rst_n = 1'b1;
    #1;
    checkOutput("midrst_release_ready", dinReady, 1'b1);
    for (int i = 0; i < 3; i++) begin
      clkStep();
      checkCycle("midrst_quiet", i, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    end
    din      = 4'h9;
    dinValid = 1'b1;
    expS = 13'b10010_00000000;
    expV = 13'b11110_00000000;
    expL = 13'b00010_00000000;
    expR = 13'b11111_00000000;
    expB = 13'b11110_00000000;
    for (int i = 0; i < 5; i++) begin
      clkStep();
      checkCycle("after_rst", i, expS[12-i], expV[12-i], expL[12-i], expR[12-i], expB[12-i]);
      if (i == 0) begin
        dinValid = 1'b0;
        din      = 4'h0;
      end
    end

    // LSB-first instance: 1011 -> 1,1,0,1.
    din2      = 4'b1011;
    dinValid2 = 1'b1;
    expS = 13'b11010_00000000;
    expV = 13'b11110_00000000;
    expL = 13'b00010_00000000;
    expB = 13'b11110_00000000;
    for (int i = 0; i < 5; i++) begin
      clkStep();
      checkOutput($sformatf("lsb_sout[%0d]", i), sout2, expS[12-i]);
      checkOutput($sformatf("lsb_valid[%0d]", i), soutValid2, expV[12-i]);
      checkOutput($sformatf("lsb_last[%0d]", i), last2, expL[12-i]);
      checkOutput($sformatf("lsb_busy[%0d]", i), busy2, expB[12-i]);
      checkOutput($sformatf("lsb_ready[%0d]", i), dinReady2, 1'b1);
      if (i == 0) begin
        dinValid2 = 1'b0;
        din2      = 4'h0;
      end
    end

    $display("CHECKS %0d ERRORS %0d", checkCount, errorCount);
    $finish;
  end

endmodule
